// File: rtl/bcd_nibble_select.sv
// Two-digit display formatter: shows an 8-bit switch value as hex or as decimal
// tens/ones (double-dabble), with a debounced push-button toggling the mode.
//   state   | meaning
//   IDLE    | waiting for sw or mode to differ from the last displayed job
//   CONVERT | double-dabble, one bit per cycle for 8 cycles
//   UPDATE  | register display outputs for the finished job
module bcd_nibble_select #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       switch,
  output logic [3:0] nibbleMS,
  output logic [3:0] nibbleLS,
  output logic       decimalMode,
  output logic       overflow,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t state, state_nxt;

  logic [7:0]    sw_meta, sw_sync;
  logic          btn_meta, btn_sync;
  logic [CW-1:0] db_cnt;
  logic          btn_db, btn_db_d;
  logic [7:0]    last_value;
  logic          last_mode;
  logic [19:0]   work, work_adj;
  logic [2:0]    iter;
  logic          start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= switch;
      btn_sync <= btn_meta;
    end
  end

  // Any sample agreeing with the debounced level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      btn_db      <= 1'b0;
      btn_db_d    <= 1'b0;
      decimalMode <= 1'b0;
    end else begin
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      btn_db_d <= btn_db;
      if (btn_db && !btn_db_d) decimalMode <= ~decimalMode;
    end
  end

  assign start = (sw_sync != last_value) || (decimalMode != last_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = decimalMode ? CONVERT : UPDATE;
      CONVERT: if (iter == 3'd7) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
  end

  always_comb begin
    work_adj = work;
    if (work[19:16] >= 4'd5) work_adj[19:16] = work[19:16] + 4'd3;
    if (work[15:12] >= 4'd5) work_adj[15:12] = work[15:12] + 4'd3;
    if (work[11:8]  >= 4'd5) work_adj[11:8]  = work[11:8]  + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value <= '0;
      last_mode  <= 1'b0;
      work       <= '0;
      iter       <= '0;
      nibbleMS   <= '0;
      nibbleLS   <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_value <= sw_sync;
            last_mode  <= decimalMode;
            work       <= {12'd0, sw_sync};
            iter       <= '0;
          end
        end
        CONVERT: begin
          work <= work_adj << 1;
          iter <= iter + 3'd1;
        end
        UPDATE: begin
          if (last_mode) begin
            nibbleMS <= work[15:12];
            nibbleLS <= work[11:8];
            overflow <= (work[19:16] != 4'd0);
          end else begin
            nibbleMS <= last_value[7:4];
            nibbleLS <= last_value[3:0];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
